// File: rtl/reg_writeback_arbiter.sv
// Write-port arbiter for the register file. Load returns take priority over ALU writebacks.
// ALU writebacks that lose arbitration wait in a small in-order FIFO.
module reg_writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rs_pending,
   output logic              rt_pending,
   output logic              rd_pending,
   output logic [CNT_W-1:0]  fifo_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0] q_rd   [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  idx;
   logic [CNT_W-1:0]  count;
   logic              alu_take;
   logic              alu_keep;
   logic              ld_keep;
   logic              empty;
   logic              push;
   logic              pop;

   // Ready looks only at the registered count so it never depends on this cycle's pop.
   assign alu_ready  = (count < CNT_W'(DEPTH));
   assign alu_take   = alu_valid && alu_ready;
   assign alu_keep   = alu_take && (alu_rd != '0);
   assign ld_keep    = ld_valid && (ld_rd != '0);
   assign empty      = (count == '0);
   assign push       = alu_keep && (ld_keep || !empty);
   assign pop        = !ld_keep && !empty;
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);

         if (ld_keep) begin
            RegWrite  <= 1'b1;
            WriteReg  <= ld_rd;
            WriteData <= ld_data;
         end else if (!empty) begin
            RegWrite  <= 1'b1;
            WriteReg  <= q_rd[head];
            WriteData <= q_data[head];
         end else if (alu_keep) begin
            RegWrite  <= 1'b1;
            WriteReg  <= alu_rd;
            WriteData <= alu_data;
         end else begin
            RegWrite  <= 1'b0;
         end
      end
   end

   // Storage is not reset; only entries inside [head, head+count) are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[tail]   <= alu_rd;
         q_data[tail] <= alu_data;
      end
   end

   always_comb begin
      rs_pending = 1'b0;
      rt_pending = 1'b0;
      rd_pending = 1'b0;
      idx        = head;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (CNT_W'(k) < count) begin
            if ((q_rd[idx] == rs_addr) && (rs_addr != '0)) rs_pending = 1'b1;
            if ((q_rd[idx] == rt_addr) && (rt_addr != '0)) rt_pending = 1'b1;
            if ((q_rd[idx] == rd_addr) && (rd_addr != '0)) rd_pending = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_reg_writeback_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              alu_valid = 1'b0;
   logic [ADDR_W-1:0] alu_rd = '0;
   logic [DATA_W-1:0] alu_data = '0;
   logic              alu_ready;
   logic              ld_valid = 1'b0;
   logic [ADDR_W-1:0] ld_rd = '0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] rs_addr = '0;
   logic [ADDR_W-1:0] rt_addr = '0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              rs_pending;
   logic              rt_pending;
   logic              rd_pending;
   logic [CNT_W-1:0]  fifo_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   reg_writeback_arbiter #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .ld_valid  (ld_valid),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rd_addr   (rd_addr),
      .rs_pending(rs_pending),
      .rt_pending(rt_pending),
      .rd_pending(rd_pending),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_t;

   // Reference model: a plain queue of waiting ALU writes and the expected output register.
   wb_t               mq[$];
   logic              m_we   = 1'b0;
   logic [ADDR_W-1:0] m_reg  = '0;
   logic [DATA_W-1:0] m_data = '0;

   always @(posedge clk) begin
      bit  acc;
      wb_t e;
      if (!rst_n) begin
         mq.delete();
         m_we   = 1'b0;
         m_reg  = '0;
         m_data = '0;
      end else begin
         acc = alu_valid && (mq.size() < DEPTH) && (alu_rd != 0);
         if (ld_valid && ld_rd != 0) begin
            m_we = 1'b1; m_reg = ld_rd; m_data = ld_data;
            if (acc) mq.push_back('{rd: alu_rd, data: alu_data});
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_reg = e.rd; m_data = e.data;
            if (acc) mq.push_back('{rd: alu_rd, data: alu_data});
         end else if (acc) begin
            m_we = 1'b1; m_reg = alu_rd; m_data = alu_data;
         end else begin
            m_we = 1'b0;
         end
      end
   end

   function automatic bit model_pending(input logic [ADDR_W-1:0] a);
      if (a == 0) return 1'b0;
      foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m.RegWrite", DATA_W'(RegWrite), DATA_W'(m_we));
         if (m_we) begin
            chk("m.WriteReg", DATA_W'(WriteReg), DATA_W'(m_reg));
            chk("m.WriteData", WriteData, m_data);
         end
         chk("m.fifo_count", DATA_W'(fifo_count), DATA_W'(mq.size()));
         chk("m.alu_ready", DATA_W'(alu_ready), DATA_W'(mq.size() < DEPTH));
         chk("m.rs_pending", DATA_W'(rs_pending), DATA_W'(model_pending(rs_addr)));
         chk("m.rt_pending", DATA_W'(rt_pending), DATA_W'(model_pending(rt_addr)));
         chk("m.rd_pending", DATA_W'(rd_pending), DATA_W'(model_pending(rd_addr)));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc;
      int k;

      // 1: reset state, then a lone ALU write bypasses the FIFO
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("rst.RegWrite", DATA_W'(RegWrite), 0);
      chk("rst.WriteReg", DATA_W'(WriteReg), 0);
      chk("rst.WriteData", WriteData, 0);
      chk("rst.count", DATA_W'(fifo_count), 0);
      chk("rst.alu_ready", DATA_W'(alu_ready), 1);
      alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hA5A5_A5A5;
      step();
      alu_valid = 1'b0;
      chk("t1.RegWrite", DATA_W'(RegWrite), 1);
      chk("t1.WriteReg", DATA_W'(WriteReg), 5);
      chk("t1.WriteData", WriteData, 32'hA5A5_A5A5);
      chk("t1.count", DATA_W'(fifo_count), 0);
      step();
      chk("t1.idle", DATA_W'(RegWrite), 0);

      // 2: load and ALU collide; ALU write waits one cycle
      ld_valid = 1'b1; ld_rd = 3; ld_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h22;
      rd_addr = 7;
      step();
      ld_valid = 1'b0; alu_valid = 1'b0;
      chk("t2.WriteReg0", DATA_W'(WriteReg), 3);
      chk("t2.WriteData0", WriteData, 32'h11);
      chk("t2.count1", DATA_W'(fifo_count), 1);
      chk("t2.rd_pending", DATA_W'(rd_pending), 1);
      step();
      chk("t2.WriteReg1", DATA_W'(WriteReg), 7);
      chk("t2.WriteData1", WriteData, 32'h22);
      chk("t2.count0", DATA_W'(fifo_count), 0);
      chk("t2.rd_clear", DATA_W'(rd_pending), 0);
      rd_addr = 0;

      // 3: five back-to-back loads fill the FIFO; fifth offer is held, then drain in order
      k = 1;
      for (int c = 0; c < 5; c++) begin
         ld_valid = 1'b1; ld_rd = ADDR_W'(20 + c); ld_data = 32'h500 + c;
         alu_valid = 1'b1; alu_rd = ADDR_W'(k); alu_data = 32'h100 + k;
         acc = alu_ready;
         step();
         if (acc) k++;
      end
      ld_valid = 1'b0;
      chk("t3.full_count", DATA_W'(fifo_count), 4);
      chk("t3.full_ready", DATA_W'(alu_ready), 0);
      chk("t3.held_rd", DATA_W'(k), 5);
      for (int j = 1; j <= 5; j++) begin
         acc = alu_valid && alu_ready;
         step();
         if (acc) alu_valid = 1'b0;
         chk("t3.drain_we", DATA_W'(RegWrite), 1);
         chk("t3.drain_reg", DATA_W'(WriteReg), DATA_W'(j));
         chk("t3.drain_data", WriteData, 32'h100 + j);
      end
      alu_valid = 1'b0;
      step();
      chk("t3.empty", DATA_W'(fifo_count), 0);

      // 4: register 0 writes vanish
      alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hDEAD;
      ld_valid = 1'b1; ld_rd = 0; ld_data = 32'hBEEF;
      step(); step();
      alu_valid = 1'b0; ld_valid = 1'b0;
      chk("t4.RegWrite", DATA_W'(RegWrite), 0);
      chk("t4.count", DATA_W'(fifo_count), 0);
      chk("t4.ready", DATA_W'(alu_ready), 1);

      // 5: reset with three queued writes discards them
      for (int c = 0; c < 3; c++) begin
         ld_valid = 1'b1; ld_rd = ADDR_W'(20 + c); ld_data = 32'h700 + c;
         alu_valid = 1'b1; alu_rd = ADDR_W'(11 + c); alu_data = 32'h900 + c;
         step();
      end
      ld_valid = 1'b0; alu_valid = 1'b0;
      chk("t5.count3", DATA_W'(fifo_count), 3);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5.RegWrite", DATA_W'(RegWrite), 0);
      chk("t5.count", DATA_W'(fifo_count), 0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("t5.no_write", DATA_W'(RegWrite), 0);
      end

      // 6: pending query against a queued write to r9
      ld_valid = 1'b1; ld_rd = 20; ld_data = 32'h33;
      alu_valid = 1'b1; alu_rd = 9; alu_data = 32'h99;
      step();
      ld_valid = 1'b0; alu_valid = 1'b0;
      rs_addr = 9; rt_addr = 0;
      #1;
      chk("t6.rs_pending", DATA_W'(rs_pending), 1);
      chk("t6.rt_pending", DATA_W'(rt_pending), 0);
      step();
      chk("t6.rs_clear", DATA_W'(rs_pending), 0);
      chk("t6.RegWrite", DATA_W'(RegWrite), 1);
      chk("t6.WriteReg", DATA_W'(WriteReg), 9);
      chk("t6.WriteData", WriteData, 32'h99);
      step(); step();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
